// File: rtl/ddr3_sim_pkg.sv
// Shared types and constants for the DDR3 Avalon-MM behavioural memory model.
package ddr3_sim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrBurst,
    StRdIssue
  } avl_state_e;

  localparam int unsigned ErrW         = 3;
  localparam int unsigned ErrRwBoth    = 0;
  localparam int unsigned ErrSizeZero  = 1;
  localparam int unsigned ErrBurstInWr = 2;

  // Index width for a table of `depth` entries, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/avl_rd_delay_pipe.sv
// Valid+data shift register giving read beats a fixed latency; data only moves with valid,
// so the output holds the last delivered beat between bursts.
module avl_rd_delay_pipe #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ddr3_avl_mem_model.sv
// Behavioural Avalon-MM burst memory standing in for the DDR3 controller user interface:
// zero-latency burst writes, fixed-latency burst reads, optional periodic stalls, sticky errors.
module ddr3_avl_mem_model
  import ddr3_sim_pkg::*;
#(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 26,
  parameter int unsigned SIZE_W       = 3,
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              ddr3_avl_ready,
  input  logic              ddr3_avl_burstbegin,
  input  logic [ADDR_W-1:0] ddr3_avl_addr,
  input  logic [SIZE_W-1:0] ddr3_avl_size,
  input  logic              ddr3_avl_read_req,
  input  logic              ddr3_avl_write_req,
  input  logic [DATA_W-1:0] ddr3_avl_wr_data,
  output logic              ddr3_avl_read_data_valid,
  output logic [DATA_W-1:0] ddr3_avl_read_data,
  output logic [ErrW-1:0]   err_flags
);

  localparam int unsigned IdxW = idx_width(MEM_DEPTH);

  avl_state_e        state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [SIZE_W-1:0] rem_q, rem_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic              rst_done_q;
  logic              stall;

  logic [DATA_W-1:0]    mem_q [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] written_q;
  logic                 mem_we;
  logic [IdxW-1:0]      mem_waddr;

  logic              issue_valid;
  logic [DATA_W-1:0] issue_data;
  logic [IdxW-1:0]   cmd_idx;
  logic [SIZE_W-1:0] eff_size;
  logic              unused_addr;

  assign cmd_idx     = ddr3_avl_addr[IdxW-1:0];
  assign unused_addr = ^ddr3_avl_addr[ADDR_W-1:IdxW];
  assign eff_size    = (ddr3_avl_size == '0) ? SIZE_W'(1) : ddr3_avl_size;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rem_q      <= '0;
      err_q      <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    if (ddr3_avl_ready) begin
      if (ddr3_avl_read_req && ddr3_avl_write_req) begin
        err_d[ErrRwBoth] = 1'b1;
      end else if (ddr3_avl_burstbegin && (ddr3_avl_read_req || ddr3_avl_write_req)) begin
        // A new burst inside a write burst truncates the old one.
        if (state_q == StWrBurst) err_d[ErrBurstInWr] = 1'b1;
        if (ddr3_avl_size == '0) err_d[ErrSizeZero] = 1'b1;
        if (ddr3_avl_write_req) begin
          mem_we    = 1'b1;
          mem_waddr = cmd_idx;
          ptr_d     = cmd_idx + 1'b1;
          rem_d     = eff_size - 1'b1;
          state_d   = (eff_size == SIZE_W'(1)) ? StIdle : StWrBurst;
        end else begin
          ptr_d   = cmd_idx;
          rem_d   = eff_size;
          state_d = StRdIssue;
        end
      end else if (state_q == StWrBurst && ddr3_avl_write_req) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == SIZE_W'(1)) state_d = StIdle;
      end
    end else if (state_q == StRdIssue) begin
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
      if (rem_q == SIZE_W'(1)) state_d = StIdle;
    end
  end

  always_comb begin
    ddr3_avl_ready = rst_done_q && (state_q != StRdIssue) && !stall;
    issue_valid    = (state_q == StRdIssue);
    // Never-written words read back as their own index.
    issue_data     = written_q[ptr_q] ? mem_q[ptr_q] : DATA_W'(ptr_q);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= ddr3_avl_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written_q <= '0;
    end else if (mem_we) begin
      written_q[mem_waddr] <= 1'b1;
    end
  end

  if (STALL_PERIOD > 0) begin : g_stall
    localparam int unsigned StallW = idx_width(STALL_PERIOD);
    localparam logic [StallW-1:0] StallLast = StallW'(STALL_PERIOD - 1);
    logic [StallW-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stall_cnt_q <= '0;
      end else begin
        stall_cnt_q <= (stall_cnt_q == StallLast) ? '0 : stall_cnt_q + 1'b1;
      end
    end

    assign stall = (stall_cnt_q == StallLast);
  end else begin : g_no_stall
    assign stall = 1'b0;
  end

  avl_rd_delay_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (issue_valid),
    .data_i  (issue_data),
    .valid_o (ddr3_avl_read_data_valid),
    .data_o  (ddr3_avl_read_data)
  );

  assign err_flags = err_q;

endmodule

// File: tb/tb_ddr3_avl_mem_model.sv
// Directed bench for ddr3_avl_mem_model: one instance without stalls, one with STALL_PERIOD=4.
module tb_ddr3_avl_mem_model;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 26;
  localparam int unsigned SW    = 3;
  localparam int unsigned RdLat = 4;

  typedef logic [6:0][DW-1:0] beats_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    beats_t        exp;
  } rd_vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          burstbegin = 1'b0;
  logic          read_req = 1'b0;
  logic          write_req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [SW-1:0] size = '0;
  logic [DW-1:0] wr_data = '0;

  logic          ready0, rvalid0, ready1, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [2:0]    err0, err1;

  logic          sel = 1'b0;
  logic          rdy, rvalid;
  logic [DW-1:0] rdata;
  logic [2:0]    err;

  int n_chk  = 0;
  int n_fail = 0;

  assign rdy    = sel ? ready1 : ready0;
  assign rvalid = sel ? rvalid1 : rvalid0;
  assign rdata  = sel ? rdata1 : rdata0;
  assign err    = sel ? err1 : err0;

  always #5 clk = ~clk;

  ddr3_avl_mem_model #(
    .DATA_W (DW), .ADDR_W (AW), .SIZE_W (SW), .MEM_DEPTH (1024),
    .RD_LATENCY (RdLat), .STALL_PERIOD (0)
  ) dut (
    .clk (clk), .reset_n (reset_n), .ddr3_avl_ready (ready0),
    .ddr3_avl_burstbegin (burstbegin), .ddr3_avl_addr (addr), .ddr3_avl_size (size),
    .ddr3_avl_read_req (read_req), .ddr3_avl_write_req (write_req),
    .ddr3_avl_wr_data (wr_data), .ddr3_avl_read_data_valid (rvalid0),
    .ddr3_avl_read_data (rdata0), .err_flags (err0)
  );

  ddr3_avl_mem_model #(
    .DATA_W (DW), .ADDR_W (AW), .SIZE_W (SW), .MEM_DEPTH (1024),
    .RD_LATENCY (RdLat), .STALL_PERIOD (4)
  ) dut_stall (
    .clk (clk), .reset_n (reset_n), .ddr3_avl_ready (ready1),
    .ddr3_avl_burstbegin (burstbegin), .ddr3_avl_addr (addr), .ddr3_avl_size (size),
    .ddr3_avl_read_req (read_req), .ddr3_avl_write_req (write_req),
    .ddr3_avl_wr_data (wr_data), .ddr3_avl_read_data_valid (rvalid1),
    .ddr3_avl_read_data (rdata1), .err_flags (err1)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the request until accepted, returns at the following negedge.
  task automatic send(input logic bb, input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [SW-1:0] s, input logic [DW-1:0] d);
    int n = 0;
    burstbegin = bb; read_req = rd; write_req = wr; addr = a; size = s; wr_data = d;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept ready", DW'(rdy), DW'(1));
    @(posedge clk);
    @(negedge clk);
    burstbegin = 1'b0; read_req = 1'b0; write_req = 1'b0; addr = '0; size = '0; wr_data = '0;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input beats_t exp, input bit chk_ready);
    int n = (s == '0) ? 1 : int'(s);
    send(1'b1, 1'b1, 1'b0, a, s, '0);
    for (int k = 0; k < int'(RdLat) + n + 1; k++) begin
      if (chk_ready) check({name, " ready"}, DW'(rdy), DW'(k >= n));
      check({name, " valid"}, DW'(rvalid), DW'(k >= int'(RdLat) - 1 && k < int'(RdLat) - 1 + n));
      if (rvalid && k >= int'(RdLat) - 1 && k < int'(RdLat) - 1 + n)
        check({name, " data"}, rdata, exp[k - int'(RdLat) + 1]);
      @(negedge clk);
    end
  endtask

  initial begin
    rd_vec_t vecs [6];
    beats_t  e;

    vecs[0] = '0; vecs[0].addr = 26'h10;  vecs[0].size = 3'd4;
    for (int j = 0; j < 4; j++) vecs[0].exp[j] = DW'(8'hA0 + j);
    vecs[1] = '0; vecs[1].addr = 26'h3FE; vecs[1].size = 3'd3;
    vecs[1].exp[0] = DW'(12'h3FE); vecs[1].exp[1] = DW'(12'h3FF); vecs[1].exp[2] = '0;
    vecs[2] = '0; vecs[2].addr = 26'h20;  vecs[2].size = 3'd4;
    vecs[2].exp[0] = DW'(8'hB0); vecs[2].exp[1] = DW'(8'hB1);
    vecs[2].exp[2] = DW'(8'h22); vecs[2].exp[3] = DW'(8'h23);
    vecs[3] = '0; vecs[3].addr = 26'h40;  vecs[3].size = 3'd3;
    for (int j = 0; j < 3; j++) vecs[3].exp[j] = DW'(8'hD0 + j);
    vecs[4] = '0; vecs[4].addr = 26'h11;  vecs[4].size = 3'd0;
    vecs[4].exp[0] = DW'(8'hA1);
    vecs[5] = '0; vecs[5].addr = 26'h12;  vecs[5].size = 3'd2;
    vecs[5].exp[0] = DW'(8'hA2); vecs[5].exp[1] = DW'(8'hA3);

    // Reset values.
    #1;
    check("rst ready", DW'(rdy), '0);
    check("rst valid", DW'(rvalid), '0);
    check("rst data", rdata, '0);
    check("rst err", DW'(err), '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready before first edge", DW'(rdy), '0);
    @(negedge clk);
    check("ready after first edge", DW'(rdy), DW'(1));

    // Burst write A0..A3 at 0x10.
    send(1'b1, 1'b0, 1'b1, 26'h10, 3'd4, DW'(8'hA0));
    for (int j = 1; j < 4; j++) send(1'b0, 1'b0, 1'b1, '0, '0, DW'(8'hA0 + j));

    // Read and write together: ignored, err[0].
    send(1'b1, 1'b1, 1'b1, 26'h10, 3'd1, DW'(16'hDEAD));
    check("rw both err", DW'(err), DW'(3'b001));
    check("rw both ready", DW'(rdy), DW'(1));

    // burstbegin on beat 2 of a 5-beat write truncates it.
    send(1'b1, 1'b0, 1'b1, 26'h20, 3'd5, DW'(8'hB0));
    send(1'b0, 1'b0, 1'b1, '0, '0, DW'(8'hB1));
    send(1'b1, 1'b0, 1'b1, 26'h40, 3'd3, DW'(8'hD0));
    send(1'b0, 1'b0, 1'b1, '0, '0, DW'(8'hD1));
    send(1'b0, 1'b0, 1'b1, '0, '0, DW'(8'hD2));
    check("bb-in-burst err", DW'(err), DW'(3'b101));
    check("bb-in-burst idle", DW'(rdy), DW'(1));

    for (int i = 0; i < 6; i++)
      do_read($sformatf("rd%0d", i), vecs[i].addr, vecs[i].size, vecs[i].exp, 1'b1);
    check("size0 err", DW'(err), DW'(3'b111));

    // Single-beat write immediately followed by a read of the same word.
    e = '0; e[0] = DW'(8'hEE);
    send(1'b1, 1'b0, 1'b1, 26'h60, 3'd1, DW'(8'hEE));
    do_read("b2b", 26'h60, 3'd1, e, 1'b1);

    // Reset after two of six beats are delivered.
    send(1'b1, 1'b1, 1'b0, 26'h30, 3'd6, '0);
    repeat (int'(RdLat) - 1) @(negedge clk);
    check("mid-rd beat0 valid", DW'(rvalid), DW'(1));
    check("mid-rd beat0 data", rdata, DW'(8'h30));
    @(negedge clk);
    check("mid-rd beat1 valid", DW'(rvalid), DW'(1));
    check("mid-rd beat1 data", rdata, DW'(8'h31));
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async rst valid", DW'(rvalid), '0);
    check("async rst ready", DW'(rdy), '0);
    check("async rst err", DW'(err), '0);
    check("async rst data", rdata, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel ready low", DW'(rdy), '0);
    @(negedge clk);
    check("rel ready high", DW'(rdy), DW'(1));
    for (int k = 0; k < 10; k++) begin
      check("no valid after rst", DW'(rvalid), '0);
      @(negedge clk);
    end

    // Stalling instance: fresh reset, then ready pattern and held write beats.
    sel = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("stall ready k%0d", k), DW'(rdy), DW'((k % 4) != 3));
    end
    send(1'b1, 1'b0, 1'b1, 26'h100, 3'd7, DW'(8'hC0));
    for (int j = 1; j < 7; j++) send(1'b0, 1'b0, 1'b1, '0, '0, DW'(8'hC0 + j));
    e = '0;
    for (int j = 0; j < 7; j++) e[j] = DW'(8'hC0 + j);
    do_read("stall rd", 26'h100, 3'd7, e, 1'b0);
    e = '0; e[0] = DW'(12'h107);
    do_read("stall past end", 26'h107, 3'd1, e, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/ddr3_avl_mem_model.md
# ddr3_avl_mem_model

Parametrised behavioural Avalon-MM memory model that stands in for the DDR3 controller's user-side interface in block-level simulation of the frame-buffer path. It accepts burst writes and burst reads on the `ddr3_avl_*` interface and stores data in an internal word array. Read data returns after a programmable fixed latency. Periodic `ready` back-pressure can be injected. Protocol errors are flagged instead of being silently absorbed.

## Interface
- `DATA_W`, 128, width of one beat
- `ADDR_W`, 26, word address width
- `SIZE_W`, 3, burst-size field width; legal sizes are 1..2^SIZE_W-1
- `MEM_DEPTH`, 1024, modelled words; address is taken modulo `MEM_DEPTH` (power of two)
- `RD_LATENCY`, 4, cycles from read-command acceptance to first `rdata_valid`; must be >= 2
- `STALL_PERIOD`, 0, 0 = no injected stalls; N>0 = `ready` forced low one cycle in every N
- `clk  in  1  sole clock; all logic on rising edge`
- `reset_n  in  1  asynchronous, active-low reset`
- `ddr3_avl_ready  out  1  command/write-beat accept`
- `ddr3_avl_burstbegin  in  1  marks first beat of a burst`
- `ddr3_avl_addr  in  ADDR_W  burst start word address`
- `ddr3_avl_size  in  SIZE_W  burst length in beats`
- `ddr3_avl_read_req  in  1  read command`
- `ddr3_avl_write_req  in  1  write beat`
- `ddr3_avl_wr_data  in  DATA_W  write beat data`
- `ddr3_avl_read_data_valid  out  1  read beat valid`
- `ddr3_avl_read_data  out  DATA_W  read beat data`
- `err_flags  out  3  sticky: [0] read and write together, [1] size 0, [2] burstbegin inside write burst`

## Operation
- States: IDLE, WR_BURST, RD_ISSUE.
- A transfer is accepted on an edge where `ready` is high.
- IDLE + `write_req` + `burstbegin`, accepted:
  - store the beat at `addr`;
  - latch `addr+1` and `size-1` remaining;
  - go to WR_BURST, or stay in IDLE if `size`==1.
- WR_BURST, accepted `write_req`:
  - store at the latched pointer, increment it (wraps modulo `MEM_DEPTH`), decrement the remaining count;
  - at 0 remaining, go to IDLE.
- WR_BURST + `burstbegin`:
  - set `err[2]`;
  - treat the beat as the start of a new burst, truncating the old one.
- IDLE + `read_req` + `burstbegin`, accepted:
  - latch `addr` and `size`, go to RD_ISSUE.
  - RD_ISSUE issues one beat per cycle (mem[ptr], ptr+1) into the delay pipe, then returns to IDLE.
- Unwritten words read back as the word index zero-extended to `DATA_W`. A per-word written bitmap is cleared by reset.
- `size`==0: set `err[1]`; treated as 1.
- `read_req` and `write_req` both high: set `err[0]`; the command is ignored and the state is unchanged.
- `req` without `burstbegin` in IDLE: ignored.
- `ready` = out-of-reset flag AND state≠RD_ISSUE AND NOT stall.
  - Stall is a free-running counter 0..STALL_PERIOD-1; the stall is active at count STALL_PERIOD-1.
  - A stall during RD_ISSUE has no effect, since `ready` is already low.
- Reset:
  - state to IDLE;
  - delay pipe, counters, bitmap and `err_flags` cleared;
  - memory contents otherwise undefined.

## Timing
- Reset values: `ready`=0, `read_data_valid`=0, `read_data`=0, `err_flags`=0.
- `ready` is first high in the cycle after the first edge following `reset_n` release.
- Read command accepted at edge T:
  - `ready` is low for cycles T+1..T+size and high again from T+size+1;
  - beat i has `read_data_valid`=1 at cycle T+RD_LATENCY+i, contiguous, with no gaps.
- A write beat accepted at edge W is visible to any read beat issued after W. A write followed by a read to the same address with no idle cycle returns the new data.
- `read_data` holds its last value when not valid. The verification bench checks it only while `read_data_valid`=1.
- Write beats take zero latency. The only back-pressure is stall cycles, during which the beat must be held.
- An asynchronous reset during RD_ISSUE or while beats are in the pipe kills all pending beats. No `read_data_valid` appears after reset release.

## Structure
- Package `ddr3_sim_pkg` holds:
  - the state enum (IDLE, WR_BURST, RD_ISSUE);
  - the `err_flags` bit-index constants;
  - the address/size helper widths.
- Sub-module `avl_rd_delay_pipe` (parameters `DATA_W`, `DEPTH`=RD_LATENCY-1) is a valid+data shift register with asynchronous clear.
- Top level contains the FSM, memory array, written bitmap and stall counter: roughly 200 lines total.

## Test plan
- Reset release, `STALL_PERIOD`=0: write 4 beats 0xA0..0xA3 at addr 0x10, read size 4 at 0x10 at edge T -> valid at T+4..T+7 with data 0xA0..0xA3; `ready` high again at T+5.
- Read never-written addr 0x3FE size 3 (`MEM_DEPTH`=1024) -> data 0x3FE, 0x3FF, 0x000, showing wrap-around.
- `STALL_PERIOD`=4, 7-beat write held through stalls -> all 7 beats stored exactly once; readback matches.
- `read_req` and `write_req` together -> `err_flags`=3'b001, memory unchanged. `size`=0 read -> 1 beat returned, `err[1]` set.
- `burstbegin` on beat 2 of a 5-beat write at 0x20 (new addr 0x40) -> `err[2]` set; 0x20/0x21 written, 0x40.. receives the new burst.
- Assert `reset_n` low mid-read (2 of 6 beats delivered) -> `read_data_valid` drops immediately and stays 0; `ready` returns one cycle after release.
